// File: rtl/mc_pkg.sv
// rtl/mc_pkg.sv - state encodings, opcodes, select constants and control word for mc_controller (MC_ADDI_EN)
package mc_pkg;

   // FSM state encodings
   localparam logic [3:0] S_FETCH   = 4'd0;
   localparam logic [3:0] S_DECODE  = 4'd1;
   localparam logic [3:0] S_MEMADR  = 4'd2;
   localparam logic [3:0] S_MEMRD   = 4'd3;
   localparam logic [3:0] S_MEMWB   = 4'd4;
   localparam logic [3:0] S_MEMWR   = 4'd5;
   localparam logic [3:0] S_RTYPEEX = 4'd6;
   localparam logic [3:0] S_RTYPEWB = 4'd7;
   localparam logic [3:0] S_BEQEX   = 4'd8;
   localparam logic [3:0] S_ADDIEX  = 4'd9;
   localparam logic [3:0] S_ADDIWB  = 4'd10;
   localparam logic [3:0] S_JEX     = 4'd11;

   // Opcodes
   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_J     = 6'b000010;

   // ALU decoder request
   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT = 2'b10;

   // ALU B operand selects
   localparam logic [1:0] SRCB_RT    = 2'b00;
   localparam logic [1:0] SRCB_FOUR  = 2'b01;
   localparam logic [1:0] SRCB_IMM   = 2'b10;
   localparam logic [1:0] SRCB_IMMSH = 2'b11;

   // PC source selects
   localparam logic [1:0] PCSRC_ALU    = 2'b00;
   localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
   localparam logic [1:0] PCSRC_JUMP   = 2'b10;

   // Raw per-state control word, before memready/zero/reset gating
   typedef struct packed {
      logic       pcwrite;
      logic       branch;
      logic       irwrite;
      logic       memwrite;
      logic       regwrite;
      logic       iord;
      logic       alusrca;
      logic [1:0] alusrcb;
      logic       regdst;
      logic       memtoreg;
      logic [1:0] pcsrc;
      logic [1:0] aluop;
   } ctrl_t;

   // DECODE dispatch; FETCH as the result marks an unrecognised opcode
   function automatic logic [3:0] decode_dispatch(input logic [5:0] op);
      logic [3:0] nxt;
      case (op)
         OP_LW, OP_SW: nxt = S_MEMADR;
         OP_RTYPE:     nxt = S_RTYPEEX;
         OP_BEQ:       nxt = S_BEQEX;
         OP_J:         nxt = S_JEX;
`ifdef MC_ADDI_EN
         OP_ADDI:      nxt = S_ADDIEX;
`endif
         default:      nxt = S_FETCH;
      endcase
      return nxt;
   endfunction

endpackage

// File: rtl/mc_outdec.sv
// rtl/mc_outdec.sv - combinational state to control-word decode (MC_ADDI_EN adds ADDIEX/ADDIWB)
module mc_outdec
   import mc_pkg::*;
(
   input  logic [3:0] i_state,
   output ctrl_t      o_ctrl
);

   // Moore decode: every control defaults to 0, each state raises only its own
   always_comb begin
      o_ctrl = '0;
      case (i_state)
         S_FETCH: begin
            o_ctrl.alusrcb = SRCB_FOUR;
            o_ctrl.irwrite = 1'b1;
            o_ctrl.pcwrite = 1'b1;
         end
         S_DECODE: o_ctrl.alusrcb = SRCB_IMMSH;
         S_MEMADR: begin
            o_ctrl.alusrca = 1'b1;
            o_ctrl.alusrcb = SRCB_IMM;
         end
         S_MEMRD: o_ctrl.iord = 1'b1;
         S_MEMWB: begin
            o_ctrl.memtoreg = 1'b1;
            o_ctrl.regwrite = 1'b1;
         end
         S_MEMWR: begin
            o_ctrl.iord     = 1'b1;
            o_ctrl.memwrite = 1'b1;
         end
         S_RTYPEEX: begin
            o_ctrl.alusrca = 1'b1;
            o_ctrl.aluop   = ALUOP_FUNCT;
         end
         S_RTYPEWB: begin
            o_ctrl.regdst   = 1'b1;
            o_ctrl.regwrite = 1'b1;
         end
         S_BEQEX: begin
            o_ctrl.alusrca = 1'b1;
            o_ctrl.aluop   = ALUOP_SUB;
            o_ctrl.pcsrc   = PCSRC_ALUOUT;
            o_ctrl.branch  = 1'b1;
         end
`ifdef MC_ADDI_EN
         S_ADDIEX: begin
            o_ctrl.alusrca = 1'b1;
            o_ctrl.alusrcb = SRCB_IMM;
         end
         S_ADDIWB: o_ctrl.regwrite = 1'b1;
`endif
         S_JEX: begin
            o_ctrl.pcsrc   = PCSRC_JUMP;
            o_ctrl.pcwrite = 1'b1;
         end
         default: o_ctrl = '0;
      endcase
   end

endmodule

// File: rtl/mc_controller.sv
// rtl/mc_controller.sv - multicycle MIPS main control FSM (MC_ADDI_EN enables addi states)
module mc_controller
   import mc_pkg::*;
#(
   parameter int STATE_W = 4
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [5:0]         op,
   input  logic               zero,
   input  logic               memready,
   output logic               pcen,
   output logic               irwrite,
   output logic               memwrite,
   output logic               regwrite,
   output logic               iord,
   output logic               alusrca,
   output logic [1:0]         alusrcb,
   output logic               regdst,
   output logic               memtoreg,
   output logic [1:0]         pcsrc,
   output logic [1:0]         aluop,
   output logic               illegal,
   output logic [STATE_W-1:0] state_o
);

   logic [STATE_W-1:0] r_state;
   logic [STATE_W-1:0] w_next;
   logic [3:0]         w_dispatch;
   logic               w_pcwrite;
   ctrl_t              w_ctrl;

   mc_outdec u_outdec (
      .i_state (r_state),
      .o_ctrl  (w_ctrl)
   );

   assign w_dispatch = decode_dispatch(op);

   // Next-state: memory states wait on memready, everything else advances unconditionally
   always_comb begin
      w_next = S_FETCH;
      case (r_state)
         S_FETCH:   w_next = memready ? S_DECODE : S_FETCH;
         S_DECODE:  w_next = w_dispatch;
         S_MEMADR:  w_next = (op == OP_SW) ? S_MEMWR : S_MEMRD;
         S_MEMRD:   w_next = memready ? S_MEMWB : S_MEMRD;
         S_MEMWB:   w_next = S_FETCH;
         S_MEMWR:   w_next = memready ? S_FETCH : S_MEMWR;
         S_RTYPEEX: w_next = S_RTYPEWB;
         S_RTYPEWB: w_next = S_FETCH;
         S_BEQEX:   w_next = S_FETCH;
`ifdef MC_ADDI_EN
         S_ADDIEX:  w_next = S_ADDIWB;
         S_ADDIWB:  w_next = S_FETCH;
`endif
         S_JEX:     w_next = S_FETCH;
         default:   w_next = S_FETCH;
      endcase
   end

   // State register; reset aborts any instruction in flight
   always_ff @(posedge clk) begin
      if (reset)
         r_state <= S_FETCH;
      else
         r_state <= w_next;
   end

   // The PC only advances out of FETCH once the instruction word has arrived
   assign w_pcwrite = w_ctrl.pcwrite & ((r_state != S_FETCH) | memready);

   // Architectural writes are suppressed while reset is high
   assign pcen     = ~reset & (w_pcwrite | (w_ctrl.branch & zero));
   assign irwrite  = ~reset & w_ctrl.irwrite & memready;
   assign memwrite = ~reset & w_ctrl.memwrite;
   assign regwrite = ~reset & w_ctrl.regwrite;
   assign illegal  = ~reset & (r_state == S_DECODE) & (w_dispatch == S_FETCH);

   assign iord     = w_ctrl.iord;
   assign alusrca  = w_ctrl.alusrca;
   assign alusrcb  = w_ctrl.alusrcb;
   assign regdst   = w_ctrl.regdst;
   assign memtoreg = w_ctrl.memtoreg;
   assign pcsrc    = w_ctrl.pcsrc;
   assign aluop    = w_ctrl.aluop;
   assign state_o  = r_state;

endmodule

// File: tb/tb_mc_controller.sv
// tb/tb_mc_controller.sv - directed self-checking bench for mc_controller (honours MC_ADDI_EN)
module tb_mc_controller;

   logic       clk;
   logic       reset;
   logic [5:0] op;
   logic       zero;
   logic       memready;
   logic       pcen, irwrite, memwrite, regwrite, iord, alusrca, regdst, memtoreg, illegal;
   logic [1:0] alusrcb, pcsrc, aluop;
   logic [3:0] state_o;

   int n_vec;
   int n_err;

   mc_controller #(.STATE_W(4)) dut (
      .clk      (clk),
      .reset    (reset),
      .op       (op),
      .zero     (zero),
      .memready (memready),
      .pcen     (pcen),
      .irwrite  (irwrite),
      .memwrite (memwrite),
      .regwrite (regwrite),
      .iord     (iord),
      .alusrca  (alusrca),
      .alusrcb  (alusrcb),
      .regdst   (regdst),
      .memtoreg (memtoreg),
      .pcsrc    (pcsrc),
      .aluop    (aluop),
      .illegal  (illegal),
      .state_o  (state_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      step();
      reset = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1; memready = 1'b1; op = 6'b000000; zero = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step();
         n_vec++;
         if (pcen !== 1'b0 || irwrite !== 1'b0 || regwrite !== 1'b0) begin
            n_err++;
            $display("FAIL reset_hold cyc %0d: pcen=%b irwrite=%b regwrite=%b, need 0/0/0", i, pcen, irwrite, regwrite);
         end
      end
      reset = 1'b0;
      #1;
      n_vec++;
      if (state_o !== 4'd0 || pcen !== 1'b1 || irwrite !== 1'b1 || alusrcb !== 2'b01) begin
         n_err++;
         $display("FAIL reset_release: state=%0d pcen=%b irwrite=%b alusrcb=%b, need 0/1/1/01", state_o, pcen, irwrite, alusrcb);
      end
      step();
      n_vec++;
      if (state_o !== 4'd1 || alusrcb !== 2'b11) begin
         n_err++;
         $display("FAIL reset_decode: state=%0d alusrcb=%b, need 1/11", state_o, alusrcb);
      end
   endtask

   task automatic test_fetch_stall();
      do_reset();
      memready = 1'b0; op = 6'b000000;
      for (int i = 0; i < 2; i++) begin
         #1;
         n_vec++;
         if (state_o !== 4'd0 || pcen !== 1'b0 || irwrite !== 1'b0) begin
            n_err++;
            $display("FAIL fetch_stall cyc %0d: state=%0d pcen=%b irwrite=%b, need 0/0/0", i, state_o, pcen, irwrite);
         end
         step();
      end
      memready = 1'b1;
   endtask

   task automatic test_lw();
      int exp_st[8] = '{0, 1, 2, 3, 3, 3, 4, 0};
      logic mr[8]   = '{1, 1, 1, 0, 0, 1, 1, 1};
      do_reset();
      op = 6'b100011;
      for (int i = 0; i < 8; i++) begin
         memready = mr[i];
         #1;
         n_vec++;
         if (state_o !== exp_st[i][3:0] || regwrite !== (exp_st[i] == 4)) begin
            n_err++;
            $display("FAIL lw cyc %0d: state=%0d regwrite=%b, need %0d/%b", i, state_o, regwrite, exp_st[i], exp_st[i] == 4);
         end
         if (exp_st[i] == 3 && iord !== 1'b1) begin
            n_err++;
            $display("FAIL lw_iord cyc %0d: iord=%b, need 1", i, iord);
         end
         if (exp_st[i] == 4 && memtoreg !== 1'b1) begin
            n_err++;
            $display("FAIL lw_memtoreg: memtoreg=%b, need 1", memtoreg);
         end
         step();
      end
      memready = 1'b1;
   endtask

   task automatic test_sw();
      int exp_st[6] = '{0, 1, 2, 5, 5, 0};
      logic mr[6]   = '{1, 1, 1, 0, 1, 1};
      int wr_cnt = 0;
      do_reset();
      op = 6'b101011;
      for (int i = 0; i < 6; i++) begin
         memready = mr[i];
         #1;
         if (memwrite === 1'b1) wr_cnt++;
         n_vec++;
         if (state_o !== exp_st[i][3:0] || regwrite !== 1'b0 || memwrite !== (exp_st[i] == 5)) begin
            n_err++;
            $display("FAIL sw cyc %0d: state=%0d regwrite=%b memwrite=%b, need %0d/0/%b", i, state_o, regwrite, memwrite, exp_st[i], exp_st[i] == 5);
         end
         step();
      end
      n_vec++;
      if (wr_cnt != 2) begin
         n_err++;
         $display("FAIL sw_memwrite_count: got %0d cycles, need 2", wr_cnt);
      end
   endtask

   task automatic test_beq(input logic z);
      int exp_st[4] = '{0, 1, 8, 0};
      do_reset();
      op = 6'b000100; zero = z; memready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         #1;
         n_vec++;
         if (state_o !== exp_st[i][3:0]) begin
            n_err++;
            $display("FAIL beq z=%b cyc %0d: state=%0d, need %0d", z, i, state_o, exp_st[i]);
         end
         if (exp_st[i] == 1 && pcen !== 1'b0) begin
            n_err++;
            $display("FAIL beq_decode_pcen z=%b: pcen=%b, need 0", z, pcen);
         end
         if (exp_st[i] == 8 && (pcen !== z || pcsrc !== 2'b01 || aluop !== 2'b01)) begin
            n_err++;
            $display("FAIL beq_ex z=%b: pcen=%b pcsrc=%b aluop=%b, need %b/01/01", z, pcen, pcsrc, aluop, z);
         end
         step();
      end
      zero = 1'b0;
   endtask

   task automatic test_rtype();
      int exp_st[5] = '{0, 1, 6, 7, 0};
      do_reset();
      op = 6'b000000; memready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         #1;
         n_vec++;
         if (state_o !== exp_st[i][3:0] || regwrite !== (exp_st[i] == 7)) begin
            n_err++;
            $display("FAIL rtype cyc %0d: state=%0d regwrite=%b, need %0d/%b", i, state_o, regwrite, exp_st[i], exp_st[i] == 7);
         end
         if (exp_st[i] == 6 && (aluop !== 2'b10 || alusrca !== 1'b1 || alusrcb !== 2'b00)) begin
            n_err++;
            $display("FAIL rtype_ex: aluop=%b alusrca=%b alusrcb=%b, need 10/1/00", aluop, alusrca, alusrcb);
         end
         if (exp_st[i] == 7 && regdst !== 1'b1) begin
            n_err++;
            $display("FAIL rtype_wb: regdst=%b, need 1", regdst);
         end
         step();
      end
   endtask

   task automatic test_j();
      int exp_st[4] = '{0, 1, 11, 0};
      do_reset();
      op = 6'b000010; memready = 1'b0;
      step();
      memready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         #1;
         n_vec++;
         if (state_o !== exp_st[i][3:0]) begin
            n_err++;
            $display("FAIL j cyc %0d: state=%0d, need %0d", i, state_o, exp_st[i]);
         end
         if (exp_st[i] == 11) begin
            memready = 1'b0;
            #1;
            n_vec++;
            if (pcen !== 1'b1 || pcsrc !== 2'b10) begin
               n_err++;
               $display("FAIL j_ex: pcen=%b pcsrc=%b, need 1/10", pcen, pcsrc);
            end
            memready = 1'b1;
         end
         step();
      end
   endtask

   task automatic test_illegal(input logic [5:0] bad_op);
      int exp_st[3] = '{0, 1, 0};
      do_reset();
      op = bad_op; memready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         #1;
         n_vec++;
         if (state_o !== exp_st[i][3:0] || illegal !== (i == 1)) begin
            n_err++;
            $display("FAIL illegal op=%b cyc %0d: state=%0d illegal=%b, need %0d/%b", bad_op, i, state_o, illegal, exp_st[i], i == 1);
         end
         step();
      end
   endtask

   task automatic test_addi();
`ifdef MC_ADDI_EN
      int exp_st[5] = '{0, 1, 9, 10, 0};
      do_reset();
      op = 6'b001000; memready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         #1;
         n_vec++;
         if (state_o !== exp_st[i][3:0] || regwrite !== (exp_st[i] == 10) || illegal !== 1'b0) begin
            n_err++;
            $display("FAIL addi cyc %0d: state=%0d regwrite=%b illegal=%b, need %0d/%b/0", i, state_o, regwrite, illegal, exp_st[i], exp_st[i] == 10);
         end
         if (exp_st[i] == 9 && (alusrca !== 1'b1 || alusrcb !== 2'b10)) begin
            n_err++;
            $display("FAIL addi_ex: alusrca=%b alusrcb=%b, need 1/10", alusrca, alusrcb);
         end
         step();
      end
`else
      test_illegal(6'b001000);
`endif
   endtask

   task automatic test_reset_in_memwr();
      do_reset();
      op = 6'b101011; memready = 1'b1;
      step(); step(); step();
      memready = 1'b0;
      #1;
      n_vec++;
      if (state_o !== 4'd5 || memwrite !== 1'b1) begin
         n_err++;
         $display("FAIL rst_memwr_pre: state=%0d memwrite=%b, need 5/1", state_o, memwrite);
      end
      reset = 1'b1;
      #1;
      n_vec++;
      if (memwrite !== 1'b0 || pcen !== 1'b0 || regwrite !== 1'b0) begin
         n_err++;
         $display("FAIL rst_memwr_gate: memwrite=%b pcen=%b regwrite=%b, need 0/0/0", memwrite, pcen, regwrite);
      end
      step();
      reset = 1'b0;
      memready = 1'b1;
      #1;
      n_vec++;
      if (state_o !== 4'd0) begin
         n_err++;
         $display("FAIL rst_memwr_post: state=%0d, need 0", state_o);
      end
   endtask

   initial begin
      n_vec = 0;
      n_err = 0;
      reset = 1'b1; op = '0; zero = 1'b0; memready = 1'b1;
      test_reset();
      test_fetch_stall();
      test_lw();
      test_sw();
      test_beq(1'b1);
      test_beq(1'b0);
      test_rtype();
      test_j();
      test_illegal(6'b111111);
      test_addi();
      test_reset_in_memwr();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
